// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, 16x oversampled mid-bit sampling,
// optional odd/even parity, one-clk done pulse with flags held until the next frame.
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_rx,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   output logic [7:0] data_out,
   output logic       active_flag,
   output logic       done_flag,
   output logic       parity_error,
   output logic       stop_error
);

   localparam int DIV_2400  = CLK_FREQ / (2400  * OVERSAMPLE);
   localparam int DIV_4800  = CLK_FREQ / (4800  * OVERSAMPLE);
   localparam int DIV_9600  = CLK_FREQ / (9600  * OVERSAMPLE);
   localparam int DIV_19200 = CLK_FREQ / (19200 * OVERSAMPLE);
   localparam int DIV_W     = (DIV_2400 > 2) ? $clog2(DIV_2400) : 1;
   localparam int TICK_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

   localparam logic [DIV_W-1:0]  DIV_M1_2400  = DIV_W'(DIV_2400 - 1);
   localparam logic [DIV_W-1:0]  DIV_M1_4800  = DIV_W'(DIV_4800 - 1);
   localparam logic [DIV_W-1:0]  DIV_M1_9600  = DIV_W'(DIV_9600 - 1);
   localparam logic [DIV_W-1:0]  DIV_M1_19200 = DIV_W'(DIV_19200 - 1);
   localparam logic [TICK_W-1:0] TICK_MID     = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t              state_q, state_d;
   logic                rx_meta, rx_sync, rx_prev;
   logic [1:0]          baud_q, parity_q;
   logic [DIV_W-1:0]    div_cnt, div_m1;
   logic [TICK_W-1:0]   tick_cnt;
   logic [2:0]          bit_cnt;
   logic [7:0]          shift_q;
   logic                par_err_q;

   logic                fall, tick, par_on, par_expect;
   logic                start_frame, clr_tick, shift_en, par_sample, finish;

   // NOTE: the synchroniser resets to the idle-line level so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge values, forming a true shift chain.
         rx_meta <= data_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall       = rx_prev & ~rx_sync;
   assign par_on     = (parity_q == 2'b01) || (parity_q == 2'b10);
   assign par_expect = (parity_q == 2'b01) ? ~^shift_q : ^shift_q;
   assign tick       = (state_q != IDLE) && (div_cnt == div_m1);

   always_comb begin
      case (baud_q)
         2'b00:   div_m1 = DIV_M1_2400;
         2'b01:   div_m1 = DIV_M1_4800;
         2'b10:   div_m1 = DIV_M1_9600;
         default: div_m1 = DIV_M1_19200;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      clr_tick    = 1'b0;
      shift_en    = 1'b0;
      par_sample  = 1'b0;
      finish      = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d     = START;
               start_frame = 1'b1;
            end
         end
         START: begin
            if (tick && tick_cnt == TICK_MID) begin
               clr_tick = 1'b1;
               state_d  = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && tick_cnt == TICK_LAST) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_d = par_on ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (tick && tick_cnt == TICK_LAST) begin
               par_sample = 1'b1;
               state_d    = STOP;
            end
         end
         STOP: begin
            if (tick && tick_cnt == TICK_LAST) begin
               finish  = 1'b1;
               state_d = rx_sync ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (rx_sync) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= 2'b00;
         parity_q  <= 2'b00;
         div_cnt   <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         par_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_frame) begin
            baud_q   <= baud_rate;
            parity_q <= parity_type;
         end
         if (state_q == IDLE || tick) div_cnt <= '0;
         else                         div_cnt <= div_cnt + 1'b1;
         if (start_frame || clr_tick) tick_cnt <= '0;
         else if (tick)               tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
         if (start_frame || clr_tick) bit_cnt <= '0;
         else if (shift_en)           bit_cnt <= bit_cnt + 1'b1;
         // LSB arrives first, so new bits enter at the top and drift down.
         if (shift_en) shift_q <= {rx_sync, shift_q[7:1]};
         if (start_frame)     par_err_q <= 1'b0;
         else if (par_sample) par_err_q <= rx_sync ^ par_expect;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out     <= 8'h00;
         active_flag  <= 1'b0;
         done_flag    <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         done_flag   <= finish;
         active_flag <= (state_d != IDLE) && (state_d != WAIT_IDLE);
         if (finish) begin
            data_out     <= shift_q;
            parity_error <= par_on & par_err_q;
            stop_error   <= ~rx_sync;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectation queue checked every cycle,
// plus literal checks after each frame.
module tb_uart_rx;

   localparam int CLK_FREQ = 3_993_600;
   localparam int OVS      = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       data_rx;
   logic [1:0] parity_type;
   logic [1:0] baud_rate;
   logic [7:0] data_out;
   logic       active_flag, done_flag, parity_error, stop_error;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_rx      (data_rx),
      .parity_type  (parity_type),
      .baud_rate    (baud_rate),
      .data_out     (data_out),
      .active_flag  (active_flag),
      .done_flag    (done_flag),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       se;
   } frame_t;

   frame_t     exp_q[$];
   frame_t     cur;
   int         compared   = 0;
   int         mismatched = 0;
   int         done_cnt   = 0;
   logic [7:0] hold_data  = 8'h00;
   logic       hold_pe    = 1'b0;
   logic       hold_se    = 1'b0;
   logic       prev_done  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bit_clks(input logic [1:0] b);
      int baud;
      baud = 2400 << b;
      return OVS * (CLK_FREQ / (baud * OVS));
   endfunction

   // Correct parity bit: even makes the total count of ones even, odd makes it odd.
   function automatic logic good_parity(input logic [7:0] d, input logic [1:0] p);
      logic ones_odd;
      ones_odd = ($countones(d) % 2) == 1;
      return (p == 2'b01) ? !ones_odd : ones_odd;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_data = 8'h00;
         hold_pe   = 1'b0;
         hold_se   = 1'b0;
         prev_done = 1'b0;
         check("rst_data_out", data_out, 8'h00);
         check("rst_active", active_flag, 0);
         check("rst_done", done_flag, 0);
         check("rst_parity_error", parity_error, 0);
         check("rst_stop_error", stop_error, 0);
      end else begin
         if (done_flag) begin
            done_cnt++;
            check("done_one_clk", prev_done, 0);
            check("active_at_done", active_flag, 0);
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               check("frame_data", data_out, cur.data);
               check("frame_parity_error", parity_error, cur.pe);
               check("frame_stop_error", stop_error, cur.se);
            end
            hold_data = data_out;
            hold_pe   = parity_error;
            hold_se   = stop_error;
         end else begin
            check("hold_data_out", data_out, hold_data);
            check("hold_parity_error", parity_error, hold_pe);
            check("hold_stop_error", stop_error, hold_se);
         end
         prev_done = done_flag;
      end
   end

   task automatic drive(input logic v, input int clks);
      data_rx = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                             input logic pbit, input logic stop_bit, input bit mid_change);
      int     n;
      int     seen;
      frame_t f;
      bit     par_on;
      n      = bit_clks(b);
      par_on = (p == 2'b01) || (p == 2'b10);
      baud_rate   = b;
      parity_type = p;
      check("active_before_frame", active_flag, 0);
      drive(1'b0, n);
      for (int i = 0; i < 8; i++) begin
         if (mid_change && i == 3) begin
            baud_rate   = 2'b11;
            parity_type = 2'b10;
         end
         if (i == 4) begin
            drive(d[i], n / 2);
            check("active_mid_frame", active_flag, 1);
            drive(d[i], n - n / 2);
         end else begin
            drive(d[i], n);
         end
      end
      if (par_on) drive(pbit, n);
      f.data = d;
      f.pe   = par_on && (pbit != good_parity(d, p));
      f.se   = !stop_bit;
      exp_q.push_back(f);
      seen = done_cnt;
      drive(stop_bit, n);
      check("done_in_stop_bit", done_cnt - seen, 1);
      check("active_after_stop", active_flag, 0);
   endtask

   initial begin
      int n;
      int seen;
      rst_n       = 1'b0;
      data_rx     = 1'b1;
      parity_type = 2'b00;
      baud_rate   = 2'b10;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1'b1, 2 * bit_clks(2'b10));

      send_frame(8'hA5, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
      check("lit_a5_data", data_out, 8'hA5);
      check("lit_a5_pe", parity_error, 0);
      check("lit_a5_se", stop_error, 0);

      n = bit_clks(2'b11);
      drive(1'b1, 2 * n);
      send_frame(8'h03, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0);
      check("lit_even_ok_data", data_out, 8'h03);
      check("lit_even_ok_pe", parity_error, 0);
      drive(1'b1, 2 * n);
      send_frame(8'h03, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0);
      check("lit_even_bad_data", data_out, 8'h03);
      check("lit_even_bad_pe", parity_error, 1);
      drive(1'b1, 2 * n);
      send_frame(8'h07, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
      check("lit_odd_ok_data", data_out, 8'h07);
      check("lit_odd_ok_pe", parity_error, 0);

      // Break: stop bit low and the line held low for three more bits.
      drive(1'b1, 2 * n);
      send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      check("lit_break_data", data_out, 8'h3C);
      check("lit_break_se", stop_error, 1);
      seen = done_cnt;
      drive(1'b0, 3 * n);
      check("break_no_retrigger_active", active_flag, 0);
      check("break_no_retrigger_done", done_cnt - seen, 0);
      drive(1'b1, 2 * n);
      send_frame(8'h55, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      check("lit_after_break_data", data_out, 8'h55);
      check("lit_after_break_se", stop_error, 0);

      // 100-clk low glitch at 19200 baud is shorter than 8 ticks and must be rejected.
      drive(1'b1, 2 * n);
      baud_rate = 2'b11;
      seen = done_cnt;
      drive(1'b0, 20);
      check("glitch_active_rises", active_flag, 1);
      drive(1'b0, 80);
      drive(1'b1, 50);
      check("glitch_active_falls", active_flag, 0);
      drive(1'b1, n);
      check("glitch_no_done", done_cnt - seen, 0);

      // Reset in the middle of the data bits of 8'hF0.
      seen = done_cnt;
      drive(1'b0, n);
      for (int i = 0; i < 4; i++) drive(1'b0, n);
      drive(1'b1, n / 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("lit_reset_data_out", data_out, 8'h00);
      check("lit_reset_active", active_flag, 0);
      drive(1'b1, 10);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1'b1, 2 * n);
      check("abort_no_done", done_cnt - seen, 0);
      check("abort_active", active_flag, 0);
      send_frame(8'h0F, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      check("lit_after_reset_data", data_out, 8'h0F);

      // Back-to-back frames at 2400 baud, with a mid-frame config change on the second.
      drive(1'b1, 2 * n);
      seen = done_cnt;
      send_frame(8'h00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      check("lit_b2b0_data", data_out, 8'h00);
      send_frame(8'hFF, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
      check("lit_b2b1_data", data_out, 8'hFF);
      send_frame(8'h81, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      check("lit_b2b2_data", data_out, 8'h81);
      check("b2b_done_count", done_cnt - seen, 3);

      drive(1'b1, 2 * n);
      check("queue_drained", exp_q.size(), 0);
      check("total_done_pulses", done_cnt, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
